key_event_decoder: RTL and testbench

- Receiving end of the debounced key interface. Consumes one debounced, active-low key level and classifies user gestures into SHORT, LONG and DOUBLE events.
- Each event is presented on a valid/ready output held until accepted, for the menu and mode logic downstream.
- One instance per key; the 3-key board uses three instances.

---
 rtl/key_evt_pkg.sv | 25 ++
 rtl/key_evt_slot.sv | 56 +++++
 rtl/key_event_decoder.sv | 157 +++++++++++++++
 tb/tb_key_event_decoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// Shared definitions for the key gesture decoder: event codes and FSM states.
// KEY_EVT_REPEAT_EN adds the auto-repeat state.
package key_evt_pkg;

   localparam int EVT_CODE_W = 2;

   typedef logic [EVT_CODE_W-1:0] evt_code_t;

   localparam evt_code_t EVT_REPEAT = 2'b00;
   localparam evt_code_t EVT_SHORT  = 2'b01;
   localparam evt_code_t EVT_LONG   = 2'b10;
   localparam evt_code_t EVT_DOUBLE = 2'b11;

   typedef enum logic [2:0] {
      ST_WAIT_REL = 3'd0,
      ST_IDLE     = 3'd1,
      ST_PRESS1   = 3'd2,
      ST_GAP      = 3'd3
`ifdef KEY_EVT_REPEAT_EN
      ,
      ST_REPEAT   = 3'd4
`endif
   } key_state_e;

endpackage

// File: rtl/key_evt_slot.sv
// Single-entry event register with valid/ready handshake and sticky drop flag.
module key_evt_slot
   import key_evt_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      load,
   input  evt_code_t code_in,
   input  logic      ready,
   input  logic      ovf_clr,
   output logic      valid,
   output evt_code_t code,
   output logic      ovf
);

   logic      valid_q, valid_d;
   evt_code_t code_q, code_d;
   logic      ovf_q, ovf_d;
   logic      slot_free;

   always_comb begin
      valid_d   = valid_q;
      code_d    = code_q;
      ovf_d     = ovf_q;
      slot_free = ~valid_q | ready;
      if (load && slot_free) begin
         valid_d = 1'b1;
         code_d  = code_in;
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
      // A drop in the same cycle as ovf_clr keeps the flag set.
      if (load && !slot_free) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         code_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         code_q  <= code_d;
         ovf_q   <= ovf_d;
      end
   end

   assign valid = valid_q;
   assign code  = code_q;
   assign ovf   = ovf_q;

endmodule

// File: rtl/key_event_decoder.sv
// Classifies one debounced active-low key into SHORT / LONG / DOUBLE events.
// Define KEY_EVT_REPEAT_EN for auto-repeat (code 00) while a LONG press is held.
module key_event_decoder
   import key_evt_pkg::*;
#(
   parameter int CNT_W      = 24,
   parameter int LONG_CNT   = 6000000,
   parameter int DCLICK_CNT = 3000000,
   parameter int REPEAT_CNT = 1200000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  key_level,
   input  logic                  evt_ready,
   output logic                  evt_valid,
   output logic [EVT_CODE_W-1:0] evt_code,
   output logic                  evt_ovf,
   input  logic                  ovf_clr
);

`ifdef KEY_EVT_REPEAT_EN
   localparam bit REPEAT_EN = 1'b1;
`else
   localparam bit REPEAT_EN = 1'b0;
`endif

   localparam longint CNT_LIM   = longint'(1) << CNT_W;
   localparam bit     DCLICK_EN = (DCLICK_CNT != 0);

   if (LONG_CNT < 2 || longint'(LONG_CNT) > CNT_LIM) begin : g_bad_long
      $error("key_event_decoder: LONG_CNT must be >= 2 and fit CNT_W");
   end
   if (DCLICK_CNT < 0 || longint'(DCLICK_CNT) > CNT_LIM) begin : g_bad_dclick
      $error("key_event_decoder: DCLICK_CNT must fit CNT_W");
   end
   if (REPEAT_EN && (REPEAT_CNT < 1 || longint'(REPEAT_CNT) > CNT_LIM)) begin : g_bad_repeat
      $error("key_event_decoder: REPEAT_CNT must be >= 1 and fit CNT_W");
   end

   localparam logic [CNT_W-1:0] LONG_TGT   = CNT_W'(LONG_CNT - 1);
   localparam logic [CNT_W-1:0] DCLICK_TGT = CNT_W'(DCLICK_EN ? DCLICK_CNT - 1 : 0);
`ifdef KEY_EVT_REPEAT_EN
   localparam logic [CNT_W-1:0] REPEAT_TGT = CNT_W'(REPEAT_CNT - 1);
`endif

   key_state_e       state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             key_prev_q, key_prev_d;
   logic             press_edge, release_edge;
   logic             emit;
   evt_code_t        emit_code;

   always_comb begin
      key_prev_d   = key_level;
      press_edge   = key_prev_q & ~key_level;
      release_edge = ~key_prev_q & key_level;
      state_d      = state_q;
      timer_d      = timer_q;
      emit         = 1'b0;
      emit_code    = EVT_SHORT;
      case (state_q)
         ST_WAIT_REL: begin
            timer_d = '0;
            if (key_level) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (press_edge) begin
               state_d = ST_PRESS1;
               timer_d = '0;
            end
         end
         ST_PRESS1: begin
            if (timer_q == LONG_TGT) begin
               emit      = 1'b1;
               emit_code = EVT_LONG;
               timer_d   = '0;
`ifdef KEY_EVT_REPEAT_EN
               state_d   = ST_REPEAT;
`else
               state_d   = ST_WAIT_REL;
`endif
            end else if (release_edge) begin
               timer_d = '0;
               if (DCLICK_EN) begin
                  state_d = ST_GAP;
               end else begin
                  emit      = 1'b1;
                  emit_code = EVT_SHORT;
                  state_d   = ST_IDLE;
               end
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         ST_GAP: begin
            // Press on the timeout cycle still counts as the second click.
            if (press_edge) begin
               emit      = 1'b1;
               emit_code = EVT_DOUBLE;
               timer_d   = '0;
               state_d   = ST_WAIT_REL;
            end else if (timer_q == DCLICK_TGT) begin
               emit      = 1'b1;
               emit_code = EVT_SHORT;
               timer_d   = '0;
               state_d   = ST_IDLE;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
`ifdef KEY_EVT_REPEAT_EN
         ST_REPEAT: begin
            // Release wins over a repeat falling due on the same cycle.
            if (release_edge) begin
               timer_d = '0;
               state_d = ST_IDLE;
            end else if (timer_q == REPEAT_TGT) begin
               emit      = 1'b1;
               emit_code = EVT_REPEAT;
               timer_d   = '0;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
`endif
         default: begin
            state_d = ST_WAIT_REL;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_WAIT_REL;
         timer_q    <= '0;
         key_prev_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         key_prev_q <= key_prev_d;
      end
   end

   key_evt_slot u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (emit),
      .code_in (emit_code),
      .ready   (evt_ready),
      .ovf_clr (ovf_clr),
      .valid   (evt_valid),
      .code    (evt_code),
      .ovf     (evt_ovf)
   );

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder with LONG_CNT=20, DCLICK_CNT=10, REPEAT_CNT=5.
module tb_key_event_decoder;

   typedef struct {
      logic [1:0]  code;
      int unsigned cyc;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       key_level;
   logic       evt_ready;
   logic       evt_valid;
   logic [1:0] evt_code;
   logic       evt_ovf;
   logic       ovf_clr;

   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   exp_t        exp_q[$];

   key_event_decoder #(
      .CNT_W      (24),
      .LONG_CNT   (20),
      .DCLICK_CNT (10),
      .REPEAT_CNT (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_level (key_level),
      .evt_ready (evt_ready),
      .evt_valid (evt_valid),
      .evt_code  (evt_code),
      .evt_ovf   (evt_ovf),
      .ovf_clr   (ovf_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_evt(input logic [1:0] code, input int unsigned at);
      exp_t e;
      e.code = code;
      e.cyc  = at;
      exp_q.push_back(e);
   endtask

   // Monitor: every newly presented event is popped from the scoreboard.
   logic pv = 1'b0;
   logic pa = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         pv <= 1'b0;
         pa <= 1'b0;
      end else begin
         if (evt_valid && (!pv || pa)) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_event: got code %0d at cycle %0d, expected none", evt_code, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("evt_code", evt_code, e.code);
               chk("evt_cycle", cyc, e.cyc);
            end
         end
         pv <= evt_valid;
         pa <= evt_valid & evt_ready;
      end
   end

   initial begin
      int unsigned t;
      rst_n     = 1'b0;
      key_level = 1'b0;
      evt_ready = 1'b1;
      ovf_clr   = 1'b0;

      // Key held through reset and for 30 cycles after: no event allowed.
      wait_cyc(3);
      chk("rst_valid", evt_valid, 0);
      chk("rst_code", evt_code, 0);
      chk("rst_ovf", evt_ovf, 0);
      rst_n = 1'b1;
      wait_cyc(30);
      key_level = 1'b1;
      wait_cyc(10);

      // SHORT: 5-cycle press, event 11 cycles after the release edge.
      key_level = 1'b0;
      wait_cyc(5);
      key_level = 1'b1;
      t = cyc;
      expect_evt(2'b01, t + 11);
      wait_cyc(20);

      // LONG: 25-cycle hold, event 21 cycles after the press edge, silent release.
      key_level = 1'b0;
      t = cyc;
      expect_evt(2'b10, t + 21);
      wait_cyc(25);
      key_level = 1'b1;
      wait_cyc(20);

      // DOUBLE: press 3, release 4, press 3; event one cycle after second press.
      key_level = 1'b0;
      wait_cyc(3);
      key_level = 1'b1;
      wait_cyc(4);
      key_level = 1'b0;
      t = cyc;
      expect_evt(2'b11, t + 1);
      wait_cyc(3);
      key_level = 1'b1;
      wait_cyc(25);

      // Long hold; release lands on the cycle the 36-cycle repeat would fire.
      key_level = 1'b0;
      t = cyc;
      expect_evt(2'b10, t + 21);
`ifdef KEY_EVT_REPEAT_EN
      expect_evt(2'b00, t + 26);
      expect_evt(2'b00, t + 31);
`endif
      wait_cyc(35);
      key_level = 1'b1;
      wait_cyc(25);

      // Overflow: LONG left pending, following SHORT is dropped.
      evt_ready = 1'b0;
      key_level = 1'b0;
      t = cyc;
      expect_evt(2'b10, t + 21);
      wait_cyc(22);
      key_level = 1'b1;
      wait_cyc(5);
      key_level = 1'b0;
      wait_cyc(3);
      key_level = 1'b1;
      wait_cyc(15);
      chk("ovf_valid_held", evt_valid, 1);
      chk("ovf_code_held", evt_code, 2);
      chk("ovf_set", evt_ovf, 1);
      ovf_clr = 1'b1;
      wait_cyc(1);
      ovf_clr = 1'b0;
      chk("ovf_cleared", evt_ovf, 0);
      chk("ovf_valid_after_clr", evt_valid, 1);
      evt_ready = 1'b1;
      wait_cyc(1);
      chk("valid_drop_after_accept", evt_valid, 0);
      wait_cyc(20);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
